up2_core: RTL

Parametrised multi-cycle accumulator processor: the second-generation core of the up-family, widened to configurable data/address widths. It replaces the bidirectional data bus with a split read/write memory port that has a request/acknowledge handshake, so it tolerates wait-stated memory. It adds subtract, AND, immediate load, conditional branch and halt. It sits between the instruction/data memory (single unified port) and the board-level debug outputs (pc, ir, acc, halted).

---
 rtl/up2_core.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/up2_core.sv
// up2_core: multi-cycle accumulator processor with a req/ack split read/write memory port.
// Build option: define UP2_CARRY_EN to enable the carry flag and the JC instruction.
module up2_core #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  localparam int OP_W = DATA_W - 4;
`ifdef UP2_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  // S_FETCH: read ir at pc | S_EXEC: decode, no request | S_MEM: data access | S_HALT: stopped
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic              r_halted;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;

  logic [3:0]        w_opc;
  logic [OP_W-1:0]   w_op;
  logic [ADDR_W-1:0] w_op_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W-1:0] w_ldi;
  logic [DATA_W-1:0] w_and;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic              w_mem_op;
  logic              w_jump;

  assign w_opc     = r_ir[DATA_W-1:DATA_W-4];
  assign w_op      = r_ir[OP_W-1:0];
  assign w_op_addr = ADDR_W'(w_op);
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_ldi     = DATA_W'(w_op);
  assign w_and     = r_acc & mem_rdata;
  assign w_sum     = {1'b0, r_acc} + {1'b0, mem_rdata};
  assign w_diff    = {1'b0, r_acc} - {1'b0, mem_rdata};
  assign w_mem_op  = (w_opc >= 4'h3) && (w_opc <= 4'h7);
  assign w_jump    = (w_opc == 4'h8) || ((w_opc == 4'h9) && r_z) ||
                     ((w_opc == 4'hA) && CARRY_EN && r_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Request is registered, so the first fetch after reset spends one cycle raising it.
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= w_pc_inc;
            r_req   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_opc == 4'h1) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_mem_op) begin
            r_req   <= 1'b1;
            r_we    <= (w_opc == 4'h3);
            r_addr  <= w_op_addr;
            r_state <= S_MEM;
          end else begin
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= w_jump ? w_op_addr : r_pc;
            r_state <= S_FETCH;
            if (w_jump) r_pc <= w_op_addr;
            if (w_opc == 4'h2) begin
              r_acc <= w_ldi;
              r_z   <= (w_ldi == '0);
              if (CARRY_EN) r_c <= 1'b0;
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_we    <= 1'b0;
            r_addr  <= r_pc;
            r_state <= S_FETCH;
            case (w_opc)
              4'h4: begin
                r_acc <= mem_rdata;
                r_z   <= (mem_rdata == '0);
                if (CARRY_EN) r_c <= 1'b0;
              end
              4'h5: begin
                r_acc <= w_sum[DATA_W-1:0];
                r_z   <= (w_sum[DATA_W-1:0] == '0);
                if (CARRY_EN) r_c <= w_sum[DATA_W];
              end
              4'h6: begin
                r_acc <= w_diff[DATA_W-1:0];
                r_z   <= (w_diff[DATA_W-1:0] == '0);
                if (CARRY_EN) r_c <= w_diff[DATA_W];
              end
              4'h7: begin
                r_acc <= w_and;
                r_z   <= (w_and == '0);
                if (CARRY_EN) r_c <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_HALT: ;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_acc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign acc       = r_acc;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign halted    = r_halted;

endmodule
